// File: rtl/rst_set_ctrl.sv
`timescale 1ns/1ps
// rst_set_ctrl
// Produces the active-low reset and set strobes for banks of async
// set/reset flops. The board reset asserts immediately and releases through
// a synchroniser followed by a hold period. From RUN, control logic can ask
// for a soft-reset pulse or a preset pulse, each HOLD_CYCLES long.
//
// Request semantics: soft_rst_req and preset_req are level requests with no
// ready handshake. They are sampled only while state_o == RUN (busy == 0). A
// request seen in RUN is accepted on that edge. Requests in any other state
// are dropped, not queued. If both are high together, the soft reset wins
// and the preset is dropped.
module rst_set_ctrl #(
   parameter int SYNC_STAGES = 2,   // reset-release synchroniser depth, >= 2
   parameter int HOLD_CYCLES = 16,  // strobe low time after sync, >= 1
   parameter int CNT_W       = 5    // HOLD_CYCLES must be < 2**CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       soft_rst_req,
   input  logic       preset_req,
   output logic       rst_n_out,
   output logic       set_n_out,
   output logic       busy,
   output logic       done,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      HOLD   = 2'b00,
      RUN    = 2'b01,
      SRST   = 2'b10,
      PRESET = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rsync;
   logic                   rst_n_q;
   logic                   set_n_q;
   logic                   busy_q;
   logic                   done_q;

   // Release synchroniser: clears instantly on reset, fills with ones after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rsync = sync_q[SYNC_STAGES-1];

   // Sequencer: every strobe and status output is a flop of its own so the
   // async inputs downstream never see decode glitches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= HOLD;
         cnt     <= '0;
         rst_n_q <= 1'b0;
         set_n_q <= 1'b1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            HOLD: begin
               if (rsync) begin
                  if (cnt == HOLD_LAST) begin
                     state   <= RUN;
                     rst_n_q <= 1'b1;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (soft_rst_req) begin
                  state   <= SRST;
                  rst_n_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else if (preset_req) begin
                  state   <= PRESET;
                  set_n_q <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            SRST: begin
               if (cnt == HOLD_LAST) begin
                  state   <= RUN;
                  rst_n_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESET: begin
               if (cnt == HOLD_LAST) begin
                  state   <= RUN;
                  set_n_q <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= HOLD;
            end
         endcase
      end
   end

   assign rst_n_out = rst_n_q;
   assign set_n_out = set_n_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign state_o   = state;

endmodule

// File: tb/tb_rst_set_ctrl.sv
`timescale 1ns/1ps
// tb_rst_set_ctrl
// Two instances: defaults (SYNC 2 / HOLD 16) and a short one (SYNC 3 /
// HOLD 1), both compared every cycle against a timing-based model.
module tb_rst_set_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       soft_rst_req = 1'b0;
   logic       preset_req = 1'b0;
   logic [1:0] rst_o;
   logic [1:0] set_o;
   logic [1:0] busy_o;
   logic [1:0] done_o;
   logic [3:0] st_o;

   int checks = 0;
   int errors = 0;

   // clock/reset block
   always #5 clk = ~clk;

   rst_set_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(16), .CNT_W(5)) u0 (
      .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
      .preset_req(preset_req), .rst_n_out(rst_o[0]), .set_n_out(set_o[0]),
      .busy(busy_o[0]), .done(done_o[0]), .state_o(st_o[1:0]));

   rst_set_ctrl #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .CNT_W(5)) u1 (
      .clk(clk), .reset(reset), .soft_rst_req(soft_rst_req),
      .preset_req(preset_req), .rst_n_out(rst_o[1]), .set_n_out(set_o[1]),
      .busy(busy_o[1]), .done(done_o[1]), .state_o(st_o[3:2]));

   // behavioural model: mode 0 hold, 1 run, 2 soft reset, 3 preset
   int syn [2] = '{2, 3};
   int hld [2] = '{16, 1};
   int m_mode [2] = '{0, 0};
   int m_since [2] = '{0, 0};
   int m_left [2] = '{0, 0};
   bit m_done [2] = '{1'b0, 1'b0};

   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (!reset) begin
            m_mode[i] = 0;
            m_since[i] = 0;
            m_done[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            case (m_mode[i])
               0: begin
                  m_since[i]++;
                  if (m_since[i] == syn[i] + hld[i]) begin
                     m_mode[i] = 1;
                     m_done[i] = 1'b1;
                  end
               end
               1: begin
                  if (soft_rst_req) begin
                     m_mode[i] = 2;
                     m_left[i] = hld[i];
                  end else if (preset_req) begin
                     m_mode[i] = 3;
                     m_left[i] = hld[i];
                  end
               end
               default: begin
                  m_left[i]--;
                  if (m_left[i] == 0) begin
                     m_mode[i] = 1;
                     m_done[i] = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard compare on every falling edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("u%0d_rst_n_out", i), 32'(rst_o[i]),
             32'(m_mode[i] == 1 || m_mode[i] == 3));
         chk($sformatf("u%0d_set_n_out", i), 32'(set_o[i]), 32'(m_mode[i] != 3));
         chk($sformatf("u%0d_busy", i), 32'(busy_o[i]), 32'(m_mode[i] != 1));
         chk($sformatf("u%0d_done", i), 32'(done_o[i]), 32'(m_done[i]));
         chk($sformatf("u%0d_state_o", i), 32'(st_o[2*i +: 2]), 32'(m_mode[i]));
         chk($sformatf("u%0d_not_both_low", i), 32'(rst_o[i] | set_o[i]), 32'd1);
      end
   end

   // hand-computed release timing, starting just after reset has risen
   task automatic check_release_seq(input string tag);
      for (int e = 1; e <= 19; e++) begin
         @(posedge clk);
         #1;
         chk({tag, "_set_high"}, 32'(set_o[0]), 32'd1);
         if (e == 3) chk({tag, "_u1_rst_e3"}, 32'(rst_o[1]), 32'd0);
         if (e == 4) chk({tag, "_u1_rst_e4"}, 32'(rst_o[1]), 32'd1);
         if (e == 17) chk({tag, "_rst_e17"}, 32'(rst_o[0]), 32'd0);
         if (e == 17) chk({tag, "_busy_e17"}, 32'(busy_o[0]), 32'd1);
         if (e == 18) chk({tag, "_rst_e18"}, 32'(rst_o[0]), 32'd1);
         if (e == 18) chk({tag, "_done_e18"}, 32'(done_o[0]), 32'd1);
         if (e == 18) chk({tag, "_busy_e18"}, 32'(busy_o[0]), 32'd0);
         if (e == 19) chk({tag, "_done_e19"}, 32'(done_o[0]), 32'd0);
      end
   endtask

   // one-cycle request pulse, then count low cycles of u0 strobes
   task automatic pulse_and_count(input bit s, input bit p, output int rlo,
                                  output int slo, output int dn, output int st1);
      @(negedge clk);
      soft_rst_req = s;
      preset_req = p;
      @(negedge clk);
      soft_rst_req = 1'b0;
      preset_req = 1'b0;
      st1 = int'(st_o[1:0]);
      rlo = 0;
      slo = 0;
      dn = 0;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge clk);
         if (!rst_o[0]) rlo++;
         if (!set_o[0]) slo++;
         if (done_o[0]) dn++;
      end
   endtask

   // driver / stimulus
   initial begin
      int rlo, slo, dn, st1;
      bit found;

      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_release_seq("por");

      pulse_and_count(1'b1, 1'b0, rlo, slo, dn, st1);
      chk("soft_rst_low_cycles", 32'(rlo), 32'd16);
      chk("soft_set_low_cycles", 32'(slo), 32'd0);
      chk("soft_done_pulses", 32'(dn), 32'd1);
      chk("soft_state", 32'(st1), 32'd2);

      pulse_and_count(1'b0, 1'b1, rlo, slo, dn, st1);
      chk("preset_set_low_cycles", 32'(slo), 32'd16);
      chk("preset_rst_low_cycles", 32'(rlo), 32'd0);
      chk("preset_done_pulses", 32'(dn), 32'd1);
      chk("preset_state", 32'(st1), 32'd3);

      pulse_and_count(1'b1, 1'b1, rlo, slo, dn, st1);
      chk("both_rst_low_cycles", 32'(rlo), 32'd16);
      chk("both_set_low_cycles", 32'(slo), 32'd0);
      chk("both_state", 32'(st1), 32'd2);

      // async reset in the fifth preset cycle, no clock edge involved
      @(negedge clk);
      preset_req = 1'b1;
      @(negedge clk);
      preset_req = 1'b0;
      repeat (4) @(negedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async_set_n", 32'(set_o[0]), 32'd1);
      chk("async_rst_n", 32'(rst_o[0]), 32'd0);
      chk("async_state", 32'(st_o[1:0]), 32'd0);
      chk("async_busy", 32'(busy_o[0]), 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_release_seq("rerst");

      // sub-cycle reset glitch still restarts the whole sequence
      @(negedge clk);
      #2 reset = 1'b0;
      #2 reset = 1'b1;
      check_release_seq("glitch");

      // preset during soft reset is dropped
      @(negedge clk);
      soft_rst_req = 1'b1;
      @(negedge clk);
      soft_rst_req = 1'b0;
      slo = 0;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         preset_req = (k == 3);
         if (!set_o[0]) slo++;
      end
      preset_req = 1'b0;
      chk("preset_in_srst_ignored", 32'(slo), 32'd0);
      repeat (3) @(negedge clk);

      // held soft request retriggers one edge after done
      soft_rst_req = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done_o[0]) begin
            found = 1'b1;
            break;
         end
      end
      chk("retrigger_done_seen", 32'(found), 32'd1);
      @(negedge clk);
      chk("retrigger_state", 32'(st_o[1:0]), 32'd2);
      soft_rst_req = 1'b0;
      repeat (20) @(negedge clk);

      // randomized requests with occasional reset drops
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         soft_rst_req = ($urandom_range(0, 11) == 0);
         preset_req = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 149) == 0) begin
            #2 reset = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
               #1 reset = 1'b1;
            end else begin
               @(negedge clk);
               reset = 1'b1;
            end
         end
      end
      soft_rst_req = 1'b0;
      preset_req = 1'b0;
      repeat (30) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
